multicycle_ctrl: RTL

Multi-cycle control sequencer for the kanade32 core. It replaces the single-cycle combinational decode path with a Moore FSM that time-shares one ALU and one unified memory port across the instruction fetch, decode, execute, memory and write-back steps. It drives all datapath muxes and enables each cycle, handshakes with memory through mem_ready, and traps on illegal opcodes or memory timeouts.

---
 rtl/multicycle_ctrl_pkg.sv | 127 ++++++++++++
 rtl/multicycle_ctrl_mem_wait_timer.sv | 38 +++
 rtl/multicycle_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the kanade32 multi-cycle controller: states, opcodes,
// ALU/mux select codes and the registered control-word payload.
package multicycle_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned ALU_OP_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_RWB      = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_IWB      = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_LWB      = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd13,
        ST_FAULT    = 4'd14
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE  = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI   = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW     = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW     = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ    = 6'b000100;
    localparam logic [OP_W-1:0] OP_J      = 6'b000010;
    localparam logic [OP_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FUNCT_SUB = 6'b100010;

    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT = 3'b111;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_RT      = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic                pc_write;
        logic                pc_write_cond;
        logic [1:0]          pc_src;
        logic                i_or_d;
        logic                mem_read;
        logic                mem_write;
        logic                reg_dst;
        logic                mem_to_reg;
        logic                reg_write;
        logic                alu_src_a;
        logic [1:0]          alu_src_b;
        logic [ALU_OP_W-1:0] alu_op;
        logic                illegal;
        logic                fault;
    } ctrl_t;

    // Moore control word for a state; the FETCH ir_write/pc_write pulses are gated outside.
    function automatic ctrl_t ctrl_decode(input state_e st, input logic [OP_W-1:0] funct);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = ALUB_FOUR;
                c.alu_op    = ALU_OP_ADD;
            end
            ST_DECODE: begin
                c.alu_src_b = ALUB_IMM_SH2;
                c.alu_op    = ALU_OP_ADD;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUB_RT;
                c.alu_op    = (funct == FUNCT_SUB) ? ALU_OP_SUB : ALU_OP_ADD;
            end
            ST_RWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUB_IMM;
                c.alu_op    = ALU_OP_ADD;
            end
            ST_IWB:    c.reg_write = 1'b1;
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_LWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = ALUB_RT;
                c.alu_op        = ALU_OP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PC_SRC_JUMP;
            end
            ST_TRAP:  c.illegal = 1'b1;
            ST_FAULT: c.fault   = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive memory wait cycles within one state and flags the cycle
// whose wait would bring the count to TIMEOUT_CYCLES (0 disables).
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_i,
    input  logic clear_i,
    output logic expired_c
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; saturate at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wait_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    assign expired_c = (TIMEOUT_CYCLES != 0) && wait_i && (cnt_q >= LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for kanade32: Moore FSM driving the shared
// ALU/memory datapath selects, with memory handshake, trap and timeout fault.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     ins_op,
    input  logic [OP_W-1:0]     func_code,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_src,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic                fault,
    output logic [STATE_W-1:0]  state
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   mem_wait_c;
    logic   expired_c;
    logic   clear_c;
    logic   fetch_done_c;
    logic   unused_alu_zero_c;

    // alu_zero is combined with pc_write_cond in the datapath, not here.
    assign unused_alu_zero_c = alu_zero;

    assign mem_wait_c = ((state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                         (state_q == ST_MEM_WR)) && !mem_ready;
    assign clear_c    = (state_d != state_q);

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wait_i    (mem_wait_c),
        .clear_i   (clear_c),
        .expired_c (expired_c)
    );

    // Next-state logic; mem_ready takes priority over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)      state_d = ST_DECODE;
                else if (expired_c) state_d = ST_FAULT;
            end
            ST_DECODE: begin
                case (ins_op)
                    OP_RTYPE: state_d = ((func_code == FUNCT_ADD) || (func_code == FUNCT_SUB))
                                        ? ST_EXEC_R : ST_TRAP;
                    OP_ADDI:  state_d = ST_EXEC_I;
                    OP_LW,
                    OP_SW:    state_d = ST_MEM_ADDR;
                    OP_BEQ:   state_d = ST_BRANCH;
                    OP_J:     state_d = ST_JUMP;
                    default:  state_d = ST_TRAP;
                endcase
            end
            ST_EXEC_R:   state_d = ST_RWB;
            ST_RWB:      state_d = ST_FETCH;
            ST_EXEC_I:   state_d = ST_IWB;
            ST_IWB:      state_d = ST_FETCH;
            ST_MEM_ADDR: state_d = (ins_op == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready)      state_d = ST_LWB;
                else if (expired_c) state_d = ST_FAULT;
            end
            ST_LWB:      state_d = ST_FETCH;
            ST_MEM_WR: begin
                if (mem_ready)      state_d = ST_FETCH;
                else if (expired_c) state_d = ST_FAULT;
            end
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            ST_FAULT:    state_d = ST_FAULT;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Registering the decode of the next state keeps outputs equal to decode(state_q).
    assign ctrl_d = ctrl_decode(state_d, func_code);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign fetch_done_c  = (state_q == ST_FETCH) && mem_ready;

    assign pc_write      = ctrl_q.pc_write | fetch_done_c;
    assign ir_write      = fetch_done_c;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign pc_src        = ctrl_q.pc_src;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign illegal       = ctrl_q.illegal;
    assign fault         = ctrl_q.fault;
    assign state         = state_q;

endmodule
